// File: rtl/wave_gen_fsm.sv
// Bounded waveform generator: operator enters low/high bounds and a mode, then
// the block runs a triangle, ramp-up or ramp-down counter. Optional: WAVE_GEN_HOLD_EN.
module wave_gen_fsm #(
    parameter int unsigned W      = 8,
    parameter int unsigned SW     = 4,
    parameter int unsigned LO_RST = 0,
    parameter int unsigned HI_RST = 1
) (
    input  logic          clc_i,
    input  logic          rst_i,
    input  logic          v_i,
    input  logic [W-1:0]  din_i,
    input  logic [1:0]    mode_i,
    input  logic [SW-1:0] step_i,
`ifdef WAVE_GEN_HOLD_EN
    input  logic          hold_i,
`endif
    output logic [W-1:0]  dind_out,
    output logic [W-1:0]  lo_out,
    output logic [W-1:0]  hi_out,
    output logic [W-1:0]  cnt_out,
    output logic [1:0]    mode_out,
    output logic [1:0]    state_out,
    output logic          err_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LO_SEL = 2'd1,
        HI_SEL = 2'd2,
        RUN    = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        M_TRI  = 2'd0,
        M_UP   = 2'd1,
        M_DOWN = 2'd2,
        M_RSVD = 2'd3
    } mode_t;

    state_t         state_q, state_d;
    logic           v_q;
    logic [W-1:0]   lo_q, lo_d;
    logic [W-1:0]   hi_q, hi_d;
    logic [W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]   dind_q, dind_d;
    logic [1:0]     mode_q, mode_d;
    logic           err_q, err_d;
    logic           down_q, down_d;

    logic           sel;
    logic           hold;
    logic [W-1:0]   span;
    logic [W:0]     step_ext;
    logic [W:0]     cnt_ext;
    logic [W:0]     span_ext;
    logic [W:0]     sum;

`ifdef WAVE_GEN_HOLD_EN
    assign hold = hold_i;
`else
    assign hold = 1'b0;
`endif

    assign sel      = v_i & ~v_q;
    assign span     = hi_q - lo_q;
    assign step_ext = (step_i == '0) ? (W+1)'(1) : {{(W+1-SW){1'b0}}, step_i};
    assign cnt_ext  = {1'b0, cnt_q};
    assign span_ext = {1'b0, span};
    // One extra bit so a large step near the top bound cannot wrap past it.
    assign sum      = cnt_ext + step_ext;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed by the combinational block.
    always_ff @(posedge clc_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            v_q     <= 1'b0;
            lo_q    <= W'(LO_RST);
            hi_q    <= W'(HI_RST);
            cnt_q   <= '0;
            dind_q  <= '0;
            mode_q  <= 2'd0;
            err_q   <= 1'b0;
            down_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            v_q     <= v_i;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            cnt_q   <= cnt_d;
            dind_q  <= dind_d;
            mode_q  <= mode_d;
            err_q   <= err_d;
            down_q  <= down_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        cnt_d   = cnt_q;
        dind_d  = dind_q;
        mode_d  = mode_q;
        err_d   = err_q;
        down_d  = down_q;

        unique case (state_q)
            IDLE: begin
                if (sel) state_d = LO_SEL;
            end

            LO_SEL: begin
                dind_d = din_i;
                if (sel) begin
                    lo_d    = din_i;
                    err_d   = 1'b0;
                    state_d = HI_SEL;
                end
            end

            HI_SEL: begin
                dind_d = din_i;
                if (sel) begin
                    if (din_i > lo_q) begin
                        hi_d    = din_i;
                        mode_d  = mode_i;
                        err_d   = 1'b0;
                        state_d = RUN;
                        if (mode_t'(mode_i) == M_DOWN) begin
                            cnt_d  = din_i - lo_q;
                            down_d = 1'b1;
                        end else begin
                            cnt_d  = '0;
                            down_d = 1'b0;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            RUN: begin
                dind_d = lo_q + cnt_q;
                if (sel) begin
                    cnt_d   = '0;
                    down_d  = 1'b0;
                    state_d = LO_SEL;
                end else if (!hold) begin
                    unique case (mode_t'(mode_q))
                        M_UP: begin
                            cnt_d = (sum > span_ext) ? '0 : sum[W-1:0];
                        end
                        M_DOWN: begin
                            cnt_d = (cnt_ext < step_ext) ? span : cnt_q - step_ext[W-1:0];
                        end
                        M_TRI, M_RSVD: begin
                            if (!down_q) begin
                                if (sum >= span_ext) begin
                                    cnt_d  = span;
                                    down_d = 1'b1;
                                end else begin
                                    cnt_d = sum[W-1:0];
                                end
                            end else begin
                                if (cnt_ext <= step_ext) begin
                                    cnt_d  = '0;
                                    down_d = 1'b0;
                                end else begin
                                    cnt_d = cnt_q - step_ext[W-1:0];
                                end
                            end
                        end
                    endcase
                end
            end
        endcase
    end

    assign dind_out  = dind_q;
    assign lo_out    = lo_q;
    assign hi_out    = hi_q;
    assign cnt_out   = cnt_q;
    assign mode_out  = mode_q;
    assign state_out = state_q;
    assign err_out   = err_q;

endmodule

// File: doc/wave_gen_fsm.md
Name: wave_gen_fsm

Overview:
Parametrised successor to the two-bound sawtooth counter FSM. An operator enters a low bound, a high bound and a waveform mode with the select button. The block then generates a bounded waveform (triangle, ramp-up or ramp-down) with a runtime step size. It sits between the switch/button debouncers and the 7-segment indication driver on the slow (4 Hz) clock domain.

Parameters:
W, 8, data width of bounds, counter and indication output
SW, 4, width of step_i
LO_RST, 0, reset value of low bound
HI_RST, 1, reset value of high bound (must be > LO_RST)

Ports:
clc_i  input  1  system clock (4 Hz), all logic on rising edge
rst_i  input  1  reset, asynchronous, active-high
v_i  input  1  select button level (debounced); block acts on its rising edge
din_i  input  W  bound value switches
mode_i  input  2  waveform mode: 0 triangle, 1 ramp-up, 2 ramp-down, 3 reserved (treated as triangle)
step_i  input  SW  step size per clock in RUN; 0 treated as 1
dind_out  output  W  indication data
lo_out  output  W  stored low bound
hi_out  output  W  stored high bound
cnt_out  output  W  offset counter (0..span)
mode_out  output  2  stored mode
state_out  output  2  current state code
err_out  output  1  bound-entry error flag

Behaviour:
- Reset (async, rst_i=1): state IDLE; lo_out=LO_RST, hi_out=HI_RST, cnt_out=0, dind_out=0, mode_out=0, state_out=0, err_out=0, direction=up, v_i edge register=0.
- Select strobe sel = v_i & ~v_q, where v_q is v_i registered. A held button produces exactly one sel.
- States: IDLE(0), LO_SEL(1), HI_SEL(2), RUN(3). state_out is the registered state code.
- IDLE: on sel -> LO_SEL.
- LO_SEL: dind_out <= din_i each clock. On sel: lo <= din_i, err_out <= 0, go to HI_SEL.
- HI_SEL: dind_out <= din_i each clock. On sel, if din_i > lo: hi <= din_i, mode <= mode_i, cnt <= 0, direction <= up (ramp-down: cnt <= span, direction <= down), go to RUN.
- HI_SEL, sel with din_i <= lo: hi unchanged, err_out <= 1, stay in HI_SEL. err_out clears on the next accepted entry.
- span = hi - lo, W bits unsigned, always >= 1 in RUN.
- RUN: dind_out <= lo + cnt (registered, modulo 2^W; lo+span=hi never overflows). dind_out lags cnt_out by one clock.
- RUN, step s = (step_i==0) ? 1 : step_i, zero-extended. Compute cnt+s / cnt-s at W+1 bits so there is no silent wrap.
- Triangle, up: if cnt+s >= span, cnt <= span and direction <= down; else cnt <= cnt+s.
- Triangle, down: if cnt <= s, cnt <= 0 and direction <= up; else cnt <= cnt-s.
- Ramp-up: if cnt+s > span, cnt <= 0; else cnt <= cnt+s.
- Ramp-down: if cnt < s, cnt <= span; else cnt <= cnt-s.
- RUN, on sel: cnt <= 0, direction <= up, go to LO_SEL. sel has priority over the counter update in that cycle.
- Reset mid-operation: immediate return to the reset values. The stored bounds are lost.
- step_i may change at any time in RUN and takes effect on the next clock.

Optional Feature:
- Macro: WAVE_GEN_HOLD_EN.
- Defined: adds input hold_i (1 bit). In RUN with hold_i=1 and no sel, cnt and direction are frozen; dind_out keeps updating to lo+cnt. sel still overrides hold_i.
- Undefined: no hold_i port; the counter always advances in RUN.

Test Plan:
- Reset then entry: rst pulse, sel with din=10, sel with din=20, mode=0, step=1 -> lo_out=10, hi_out=20, state_out=3; cnt goes 0,1,…,10,9,…,0,1; dind_out goes 10..20..10, lagging cnt by one.
- Bad bound: lo=50, then sel with din=50 -> err_out=1, state stays 2, hi unchanged. Then sel with din=60 -> err_out=0, RUN.
- Ramp with step: lo=0, hi=10, mode=1, step=4 -> cnt 0,4,8,0,4,… Same bounds with mode=2 -> cnt 10,6,2,10,6,…
- Triangle clamp: lo=0, hi=255, step=0 (treated as 1), then step=15 mid-run -> no overflow; cnt clamps at 255 and at 0.
- Held button: v_i held high for 8 clocks in IDLE -> exactly one transition (to LO_SEL only). Async rst asserted mid-RUN, off a clock edge -> all outputs at reset values immediately.
- With WAVE_GEN_HOLD_EN: hold_i=1 for 5 clocks at cnt=7 -> cnt stays 7. Then sel while hold_i=1 -> LO_SEL, cnt=0.
